hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Control end of the PA-RISC 5-stage pipeline registers. It observes the destination, load and branch information coming out of the ID/EX, EX/MEM and MEM/WB registers, and drives PC/IF_ID load enables, IF_ID clear, ID/EX bubble insertion and operand-forward selects. A small FSM sequences multi-cycle branch flushes and memory-wait freezes, and two saturating counters record stall and flush cycles.

Parameters:
FLUSH_CYCLES, 1, cycles of IF_ID clear + bubble per taken branch (1..7)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ID_RA  in  5  ID-stage source A register number
ID_RB  in  5  ID-stage source B register number
ID_USE_A  in  1  ID instruction reads RA
ID_USE_B  in  1  ID instruction reads RB
EX_RD  in  5  ID/EX destination register
EX_RF_LE  in  1  ID/EX register-file write enable
EX_L  in  1  ID/EX instruction is a load
EX_BR_TAKEN  in  1  branch/jump in EX resolved taken (includes UB)
MEM_RD  in  5  EX/MEM destination register
MEM_RF_LE  in  1  EX/MEM write enable
WB_RD  in  5  MEM/WB destination register
WB_RF_LE  in  1  MEM/WB write enable
MEM_WAIT  in  1  data memory not ready; freeze the whole pipe
PC_LE  out  1  load enable, PC front/back registers
IF_ID_LE  out  1  IF/ID load enable
IF_ID_CLR  out  1  IF/ID clear
NOP_SEL  out  1  zero all control fields entering ID/EX
PIPE_HOLD  out  1  hold ID/EX, EX/MEM, MEM/WB
FWD_A  out  2  source-A select: 00 RF, 01 EX, 10 MEM, 11 WB
FWD_B  out  2  source-B select, same encoding
STALL_CNT  out  CNT_W  cycles with load-use stall or MEM_WAIT
FLUSH_CNT  out  CNT_W  cycles with IF_ID_CLR asserted

Behaviour:
- Control outputs are combinational from the current inputs and the registered state. The FSM and counters are registered.
- Register 0 never causes a hazard or a forward, because GR0 is hardwired to zero.
- Load-use hazard (LU): EX_L & EX_RF_LE & EX_RD!=0 & ((ID_USE_A & ID_RA==EX_RD) | (ID_USE_B & ID_RB==EX_RD)).
- States: RUN, FLUSH, WAIT.
- Priority within a cycle: reset > MEM_WAIT > taken branch > LU > normal.
- RUN with MEM_WAIT=1:
  - outputs PC_LE=0, IF_ID_LE=0, IF_ID_CLR=0, NOP_SEL=0, PIPE_HOLD=1
  - next state WAIT; STALL_CNT increments
  - a branch or LU in the same cycle is ignored this cycle and re-evaluated after the wait.
- WAIT: same outputs while MEM_WAIT=1. Returns to RUN the cycle after MEM_WAIT falls, then evaluates normally. Flush progress is saved, not lost (see FLUSH).
- RUN with EX_BR_TAKEN=1:
  - outputs PC_LE=1, IF_ID_CLR=1, NOP_SEL=1, IF_ID_LE=0
  - FLUSH_CNT increments
  - if FLUSH_CYCLES>1, go to FLUSH with remaining count FLUSH_CYCLES-1; otherwise stay in RUN.
- FLUSH:
  - outputs PC_LE=1, IF_ID_CLR=1, NOP_SEL=1, IF_ID_LE=0
  - remaining count decrements; return to RUN when it reaches 0
  - LU and EX_BR_TAKEN are ignored, since those instructions are squashed
  - MEM_WAIT in FLUSH goes to WAIT with the remaining count held, then resumes FLUSH.
- RUN with LU:
  - outputs PC_LE=0, IF_ID_LE=0, NOP_SEL=1 (one bubble); STALL_CNT increments
  - the hazard clears naturally next cycle, so the state remains RUN.
- RUN with no event: PC_LE=1, IF_ID_LE=1, all other controls 0.
- Forwarding (each operand, independent of state):
  - EX match (EX_RF_LE, !EX_L, EX_RD==src, src!=0) -> 01
  - else MEM match -> 10
  - else WB match -> 11
  - else 00.
- Counters saturate at all-ones and never wrap.
- Reset values: state RUN, flush count 0, STALL_CNT=0, FLUSH_CNT=0. Outputs during the reset cycle: PC_LE=0, IF_ID_LE=0, IF_ID_CLR=1, NOP_SEL=1, PIPE_HOLD=0, FWD_A=FWD_B=00.
- Reset in any state (mid-flush or mid-wait) returns the block to RUN next cycle and drops the pending count.

Decomposition:
- Shared package pipeline_pkg holds:
  - the FWD encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB)
  - the state encoding (ST_RUN, ST_FLUSH, ST_WAIT)
  - the GR0 constant.
- One sub-module, forward_select: combinational, instantiated once per operand.
- The counters stay inline.

Test Plan:
- Reset held 2 cycles, then released with idle inputs -> IF_ID_CLR=1 and NOP_SEL=1 during reset, counters 0; first cycle after release PC_LE=1, IF_ID_LE=1.
- Load-use: EX_L=1, EX_RF_LE=1, EX_RD=5, ID_RA=5, ID_USE_A=1 -> one cycle of PC_LE=0, IF_ID_LE=0, NOP_SEL=1; STALL_CNT=1. Same stimulus with EX_RD=0 -> no stall.
- Forward priority: EX_RD=MEM_RD=WB_RD=7, all RF_LE=1, EX_L=0, ID_RB=7 -> FWD_B=01. Drop EX_RF_LE -> 10. Drop MEM_RF_LE -> 11.
- FLUSH_CYCLES=3, EX_BR_TAKEN pulse -> IF_ID_CLR=1 for exactly 3 cycles with an LU injected on cycle 2 ignored; FLUSH_CNT=3.
- FLUSH_CYCLES=3: branch, then MEM_WAIT=1 for 2 cycles on flush cycle 2 -> PIPE_HOLD=1 for 2 cycles, then 1 remaining flush cycle; STALL_CNT=2, FLUSH_CNT=3.
- Counter saturation with CNT_W=4: 20 consecutive MEM_WAIT cycles -> STALL_CNT stays at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline control slice: operand-forward selects,
// hazard FSM states and the hardwired-zero register number.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam logic [4:0] GR0 = 5'd0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-register observation and control bundle between the datapath
// (master) and the hazard control unit (slave).
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  // Handshake: none. Every signal is level-sensitive and valid every cycle;
  // inputs are sampled combinationally, counters change on the rising clock.
  logic [4:0]       ID_RA;
  logic [4:0]       ID_RB;
  logic             ID_USE_A;
  logic             ID_USE_B;
  logic [4:0]       EX_RD;
  logic             EX_RF_LE;
  logic             EX_L;
  logic             EX_BR_TAKEN;
  logic [4:0]       MEM_RD;
  logic             MEM_RF_LE;
  logic [4:0]       WB_RD;
  logic             WB_RF_LE;
  logic             MEM_WAIT;
  logic             PC_LE;
  logic             IF_ID_LE;
  logic             IF_ID_CLR;
  logic             NOP_SEL;
  logic             PIPE_HOLD;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, EX_RF_LE, EX_L, EX_BR_TAKEN,
           MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE, MEM_WAIT,
    input  PC_LE, IF_ID_LE, IF_ID_CLR, NOP_SEL, PIPE_HOLD, FWD_A, FWD_B,
           STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, EX_RF_LE, EX_L, EX_BR_TAKEN,
           MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE, MEM_WAIT,
    output PC_LE, IF_ID_LE, IF_ID_CLR, NOP_SEL, PIPE_HOLD, FWD_A, FWD_B,
           STALL_CNT, FLUSH_CNT
  );

endinterface

// File: rtl/forward_select.sv
// Operand bypass select for one ID-stage source: nearest producing stage wins.
module forward_select
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_le,
  input  logic       ex_l,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_le,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_le,
  output fwd_sel_t   sel
);

  // A load in EX has no data yet; the load-use stall covers that case.
  always_comb begin
    sel = FWD_RF;
    if (src != GR0) begin
      if (ex_rf_le && !ex_l && (ex_rd == src))
        sel = FWD_EX;
      else if (mem_rf_le && (mem_rd == src))
        sel = FWD_MEM;
      else if (wb_rf_le && (wb_rd == src))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stall/flush/freeze sequencing, operand forwarding
// and saturating stall/flush cycle counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_control_unit_if.slave  hz,
  output state_t                state_dbg
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state, state_n, eff_state;
  logic [2:0]       rem, rem_n;
  logic             lu;
  logic             pc_le, if_id_le, if_id_clr, nop_sel, pipe_hold;
  logic             stall_evt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  fwd_sel_t         fwd_a, fwd_b;

  assign lu = hz.EX_L && hz.EX_RF_LE && (hz.EX_RD != GR0) &&
              ((hz.ID_USE_A && (hz.ID_RA == hz.EX_RD)) ||
               (hz.ID_USE_B && (hz.ID_RB == hz.EX_RD)));

  // Once memory is ready the saved context acts in that same cycle.
  always_comb begin
    eff_state = state;
    if (state == ST_WAIT && !hz.MEM_WAIT)
      eff_state = (rem != 3'd0) ? ST_FLUSH : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    if (hz.MEM_WAIT) begin
      state_n = ST_WAIT;
    end else begin
      unique case (eff_state)
        ST_RUN: begin
          state_n = ST_RUN;
          if (hz.EX_BR_TAKEN && (FLUSH_CYCLES > 1)) begin
            state_n = ST_FLUSH;
            rem_n   = FLUSH_RELOAD;
          end
        end
        ST_FLUSH: begin
          rem_n   = rem - 3'd1;
          state_n = (rem == 3'd1) ? ST_RUN : ST_FLUSH;
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_le     = 1'b0;
    if_id_le  = 1'b0;
    if_id_clr = 1'b0;
    nop_sel   = 1'b0;
    pipe_hold = 1'b0;
    stall_evt = 1'b0;
    if (reset) begin
      if_id_clr = 1'b1;
      nop_sel   = 1'b1;
    end else if (hz.MEM_WAIT) begin
      pipe_hold = 1'b1;
      stall_evt = 1'b1;
    end else begin
      unique case (eff_state)
        ST_RUN: begin
          if (hz.EX_BR_TAKEN) begin
            pc_le     = 1'b1;
            if_id_clr = 1'b1;
            nop_sel   = 1'b1;
          end else if (lu) begin
            nop_sel   = 1'b1;
            stall_evt = 1'b1;
          end else begin
            pc_le    = 1'b1;
            if_id_le = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_le     = 1'b1;
          if_id_clr = 1'b1;
          nop_sel   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_clr && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  forward_select u_fwd_a (
    .src(hz.ID_RA), .ex_rd(hz.EX_RD), .ex_rf_le(hz.EX_RF_LE), .ex_l(hz.EX_L),
    .mem_rd(hz.MEM_RD), .mem_rf_le(hz.MEM_RF_LE), .wb_rd(hz.WB_RD),
    .wb_rf_le(hz.WB_RF_LE), .sel(fwd_a)
  );

  forward_select u_fwd_b (
    .src(hz.ID_RB), .ex_rd(hz.EX_RD), .ex_rf_le(hz.EX_RF_LE), .ex_l(hz.EX_L),
    .mem_rd(hz.MEM_RD), .mem_rf_le(hz.MEM_RF_LE), .wb_rd(hz.WB_RD),
    .wb_rf_le(hz.WB_RF_LE), .sel(fwd_b)
  );

  assign hz.PC_LE     = pc_le;
  assign hz.IF_ID_LE  = if_id_le;
  assign hz.IF_ID_CLR = if_id_clr;
  assign hz.NOP_SEL   = nop_sel;
  assign hz.PIPE_HOLD = pipe_hold;
  assign hz.FWD_A     = reset ? FWD_RF : fwd_a;
  assign hz.FWD_B     = reset ? FWD_RF : fwd_b;
  assign hz.STALL_CNT = stall_cnt;
  assign hz.FLUSH_CNT = flush_cnt;
  assign state_dbg    = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed and random checks of hazard_control_unit against a pending-flush
// reference model (FLUSH_CYCLES=3, CNT_W=4).
module tb_hazard_control_unit;
  import pipeline_pkg::*;

  localparam int FC    = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;
  int     checks = 0;
  int     errors = 0;

  // Reference model: flush cycles still owed and the two counter values.
  int m_flush_left = 0;
  int m_stall      = 0;
  int m_flush      = 0;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_control_unit #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hz(hz.slave), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    hz.ID_RA = 5'd0; hz.ID_RB = 5'd0; hz.ID_USE_A = 1'b0; hz.ID_USE_B = 1'b0;
    hz.EX_RD = 5'd0; hz.EX_RF_LE = 1'b0; hz.EX_L = 1'b0; hz.EX_BR_TAKEN = 1'b0;
    hz.MEM_RD = 5'd0; hz.MEM_RF_LE = 1'b0; hz.WB_RD = 5'd0; hz.WB_RF_LE = 1'b0;
    hz.MEM_WAIT = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (hz.EX_RF_LE && !hz.EX_L && hz.EX_RD == src) return 2'b01;
    if (hz.MEM_RF_LE && hz.MEM_RD == src) return 2'b10;
    if (hz.WB_RF_LE && hz.WB_RD == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Called just after a falling edge with inputs applied; checks the cycle,
  // advances the model and returns at the next falling edge.
  task automatic run_cycle(input string tag);
    logic e_pc, e_ifid, e_clr, e_nop, e_hold, lu_now, stall_ev;
    logic [1:0] e_fa, e_fb;
    #1;
    lu_now = hz.EX_L && hz.EX_RF_LE && hz.EX_RD != 5'd0 &&
             ((hz.ID_USE_A && hz.ID_RA == hz.EX_RD) || (hz.ID_USE_B && hz.ID_RB == hz.EX_RD));
    {e_pc, e_ifid, e_clr, e_nop, e_hold, stall_ev} = '0;
    if (reset) begin
      e_clr = 1'b1; e_nop = 1'b1;
    end else if (hz.MEM_WAIT) begin
      e_hold = 1'b1; stall_ev = 1'b1;
    end else if (m_flush_left > 0 || hz.EX_BR_TAKEN) begin
      e_pc = 1'b1; e_clr = 1'b1; e_nop = 1'b1;
    end else if (lu_now) begin
      e_nop = 1'b1; stall_ev = 1'b1;
    end else begin
      e_pc = 1'b1; e_ifid = 1'b1;
    end
    e_fa = reset ? 2'b00 : ref_fwd(hz.ID_RA);
    e_fb = reset ? 2'b00 : ref_fwd(hz.ID_RB);
    check({tag, ".pc_le"},     32'(hz.PC_LE),     32'(e_pc));
    check({tag, ".if_id_le"},  32'(hz.IF_ID_LE),  32'(e_ifid));
    check({tag, ".if_id_clr"}, 32'(hz.IF_ID_CLR), 32'(e_clr));
    check({tag, ".nop_sel"},   32'(hz.NOP_SEL),   32'(e_nop));
    check({tag, ".pipe_hold"}, 32'(hz.PIPE_HOLD), 32'(e_hold));
    check({tag, ".fwd_a"},     32'(hz.FWD_A),     32'(e_fa));
    check({tag, ".fwd_b"},     32'(hz.FWD_B),     32'(e_fb));
    check({tag, ".stall_cnt"}, 32'(hz.STALL_CNT), 32'(m_stall));
    check({tag, ".flush_cnt"}, 32'(hz.FLUSH_CNT), 32'(m_flush));
    if (reset) begin
      m_flush_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (stall_ev) m_stall = sat_inc(m_stall);
      if (e_clr) m_flush = sat_inc(m_flush);
      if (!hz.MEM_WAIT) begin
        if (m_flush_left > 0) m_flush_left--;
        else if (hz.EX_BR_TAKEN) m_flush_left = FC - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    run_cycle("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    run_cycle("reset0");
    run_cycle("reset1");
    reset = 1'b0;
    run_cycle("idle");

    // Load-use on source A, then the same with GR0 as destination.
    hz.EX_L = 1'b1; hz.EX_RF_LE = 1'b1; hz.EX_RD = 5'd5; hz.ID_RA = 5'd5; hz.ID_USE_A = 1'b1;
    run_cycle("lu");
    idle_inputs();
    run_cycle("lu_after");
    check("lu_stall_cnt", 32'(hz.STALL_CNT), 32'd1);
    hz.EX_L = 1'b1; hz.EX_RF_LE = 1'b1; hz.EX_RD = 5'd0; hz.ID_RA = 5'd0; hz.ID_USE_A = 1'b1;
    run_cycle("lu_gr0");

    // Forward priority on source B.
    idle_inputs();
    hz.EX_RD = 5'd7; hz.MEM_RD = 5'd7; hz.WB_RD = 5'd7; hz.ID_RB = 5'd7;
    hz.EX_RF_LE = 1'b1; hz.MEM_RF_LE = 1'b1; hz.WB_RF_LE = 1'b1;
    run_cycle("fwd_ex");
    hz.EX_RF_LE = 1'b0;
    run_cycle("fwd_mem");
    hz.MEM_RF_LE = 1'b0;
    run_cycle("fwd_wb");

    // Branch flush with an LU on flush cycle 2 that must be ignored.
    do_reset();
    hz.EX_BR_TAKEN = 1'b1;
    run_cycle("br1");
    idle_inputs();
    hz.EX_L = 1'b1; hz.EX_RF_LE = 1'b1; hz.EX_RD = 5'd3; hz.ID_RB = 5'd3; hz.ID_USE_B = 1'b1;
    run_cycle("br2_lu");
    idle_inputs();
    run_cycle("br3");
    run_cycle("br_done");
    check("br_flush_cnt", 32'(hz.FLUSH_CNT), 32'd3);
    check("br_stall_cnt", 32'(hz.STALL_CNT), 32'd0);

    // Branch flush frozen by MEM_WAIT after flush cycle 2.
    do_reset();
    hz.EX_BR_TAKEN = 1'b1;
    run_cycle("bw1");
    idle_inputs();
    run_cycle("bw2");
    hz.MEM_WAIT = 1'b1;
    run_cycle("bw_wait1");
    run_cycle("bw_wait2");
    hz.MEM_WAIT = 1'b0;
    run_cycle("bw3");
    run_cycle("bw_done");
    check("bw_stall_cnt", 32'(hz.STALL_CNT), 32'd2);
    check("bw_flush_cnt", 32'(hz.FLUSH_CNT), 32'd3);

    // Stall counter saturation.
    do_reset();
    hz.MEM_WAIT = 1'b1;
    for (int i = 0; i < 20; i++) run_cycle("sat");
    hz.MEM_WAIT = 1'b0;
    run_cycle("sat_end");
    check("sat_stall_cnt", 32'(hz.STALL_CNT), 32'(CMAX));

    // Random traffic over a small register window so matches are frequent.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      hz.ID_RA       = 5'($urandom_range(0, 3));
      hz.ID_RB       = 5'($urandom_range(0, 3));
      hz.ID_USE_A    = 1'($urandom_range(0, 1));
      hz.ID_USE_B    = 1'($urandom_range(0, 1));
      hz.EX_RD       = 5'($urandom_range(0, 3));
      hz.EX_RF_LE    = 1'($urandom_range(0, 1));
      hz.EX_L        = ($urandom_range(0, 2) == 0);
      hz.EX_BR_TAKEN = ($urandom_range(0, 7) == 0);
      hz.MEM_RD      = 5'($urandom_range(0, 3));
      hz.MEM_RF_LE   = 1'($urandom_range(0, 1));
      hz.WB_RD       = 5'($urandom_range(0, 3));
      hz.WB_RF_LE    = 1'($urandom_range(0, 1));
      hz.MEM_WAIT    = ($urandom_range(0, 6) == 0);
      run_cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
